// File: rtl/l2norm_arb_ctrl.sv
// Round-robin, per-vector arbiter that feeds one shared streaming L2-norm datapath.
// It returns each vector's final norm on a valid/ready result port.
module l2norm_arb_ctrl #(
  parameter int unsigned DP_LAT  = 2,
  parameter int unsigned MAX_LEN = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [15:0] req_a,
  input  logic [1:0]  req_last,
  output logic        dp_clear,
  output logic [7:0]  dp_a,
  output logic        dp_valid_in,
  input  logic [9:0]  dp_g,
  input  logic        dp_valid_out,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [9:0]  res_g,
  output logic        res_id,
  output logic [4:0]  res_len,
  output logic        res_err
);

  if (DP_LAT < 1 || MAX_LEN < 1 || MAX_LEN > 16) begin : g_param_check
    $error("l2norm_arb_ctrl: DP_LAT must be >= 1 and MAX_LEN within 1..16");
  end

  typedef enum logic [2:0] {IDLE, CLEAR, STREAM, DRAIN, RESULT} state_t;

  localparam logic [4:0] LAST_IDX = 5'(MAX_LEN - 1);

  state_t     state, state_nxt;
  logic       grant, rr, err;
  logic [4:0] issued, recv;
  logic       hs, at_max, done;

  assign hs     = req_valid[grant] & req_ready[grant];
  assign at_max = (issued == LAST_IDX);
  // The datapath reports every element; only the one matching the last issued one is the final norm.
  assign done   = (state == DRAIN) && dp_valid_out && ((recv + 5'd1) == issued);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (|req_valid) state_nxt = CLEAR;
      CLEAR:   state_nxt = STREAM;
      STREAM:  if (hs && (req_last[grant] || at_max)) state_nxt = DRAIN;
      DRAIN:   if (done) state_nxt = RESULT;
      RESULT:  if (res_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req_ready = '0;
    if (state == STREAM) req_ready[grant] = 1'b1;
    dp_clear    = (state == CLEAR);
    dp_valid_in = hs;
    dp_a        = '0;
    if (hs) dp_a = grant ? req_a[15:8] : req_a[7:0];
    res_valid   = (state == RESULT);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      grant   <= 1'b0;
      rr      <= 1'b0;
      err     <= 1'b0;
      issued  <= '0;
      recv    <= '0;
      res_g   <= '0;
      res_id  <= 1'b0;
      res_len <= '0;
      res_err <= 1'b0;
    end else begin
      if (state == IDLE && (|req_valid))
        grant <= (&req_valid) ? rr : req_valid[1];
      if (state == CLEAR) begin
        issued <= '0;
        recv   <= '0;
      end
      if (state == STREAM && hs) begin
        issued <= issued + 5'd1;
        if (at_max && !req_last[grant]) err <= 1'b1;
      end
      if ((state == STREAM || state == DRAIN) && dp_valid_out)
        recv <= recv + 5'd1;
      if (done) begin
        res_g   <= dp_g;
        res_len <= issued;
        res_id  <= grant;
        res_err <= err;
      end
      if (state == RESULT && res_ready) begin
        rr  <= ~grant;
        err <= 1'b0;
      end
    end
  end

endmodule

// File: doc/l2norm_arb_ctrl.md
Name: l2norm_arb_ctrl

Overview:
- Controller that shares one streaming L2-norm datapath (8-bit element in, 10-bit running norm g out, fixed pipeline latency) between two vector requesters.
- Arbitrates round-robin per whole vector, clears the datapath accumulator before each vector and streams the granted requester's elements into it with backpressure.
- Waits for the pipeline to drain, then returns the final norm with requester ID, element count and error flag on a valid/ready result port.

Parameters:
- DP_LAT, 2, cycles from the edge sampling dp_valid_in to the edge after which the matching dp_valid_out/dp_g are visible.
- MAX_LEN, 16, maximum elements per vector; ≤16 so that 16*255² gives sqrt ≤1020, which fits in 10 bits.

Ports:
- clk  in  1  single clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- req_valid  in  2  per-requester element valid
- req_ready  out  2  per-requester element accept
- req_a  in  16  element data; [7:0] requester 0, [15:8] requester 1
- req_last  in  2  marks the final element of a vector
- dp_clear  out  1  one-cycle synchronous accumulator clear to datapath
- dp_a  out  8  element to datapath
- dp_valid_in  out  1  element valid to datapath
- dp_g  in  10  datapath running norm
- dp_valid_out  in  1  datapath result valid
- res_valid  out  1  result available
- res_ready  in  1  result consumed
- res_g  out  10  final norm
- res_id  out  1  requester that owned the vector
- res_len  out  5  elements accepted (1..MAX_LEN)
- res_err  out  1  vector truncated at MAX_LEN without last

Behaviour:
- Reset (asserted, asynchronous): state=IDLE; rr pointer=0; counters=0; all outputs 0 (req_ready, dp_clear, dp_valid_in, res_valid, res_g, res_id, res_len, res_err).
- Reset mid-vector: the vector is abandoned and nothing is returned. The next vector always starts with CLEAR, so stale accumulator state is harmless.
- IDLE:
  - If exactly one req_valid is high, grant that requester.
  - If both are high, grant rr.
  - Latch the grant and go to CLEAR.
  - req_ready=0.
- CLEAR: dp_clear=1 for exactly one cycle; issued=0, recv=0; go to STREAM.
- STREAM:
  - req_ready[grant]=1; the other req_ready=0.
  - Handshake = req_valid[grant] & req_ready[grant].
  - dp_valid_in = handshake and dp_a = granted req_a slice, both combinational.
  - Each handshake increments issued.
  - Handshake with req_last, or with issued reaching MAX_LEN, goes to DRAIN. In the MAX_LEN case without req_last, set err=1.
  - Gaps (req_valid low) are allowed; the controller stays in STREAM.
- Result counting:
  - Each dp_valid_out in STREAM or DRAIN increments recv.
  - dp_valid_out in IDLE, CLEAR or RESULT is ignored.
- DRAIN:
  - req_ready=0.
  - At the edge where dp_valid_out=1 and recv+1==issued: capture res_g=dp_g, res_len=issued, res_id=grant, res_err=err; go to RESULT.
- RESULT:
  - res_valid=1; res_g, res_id, res_len and res_err are held stable while res_ready=0.
  - On res_valid & res_ready: rr=~grant, err=0, go to IDLE.
  - res_valid deasserts the cycle after the handshake.
- Latency: last element sampled at edge t → res_valid high after edge t+DP_LAT+1. Each vector also costs 2 cycles of overhead (IDLE grant, CLEAR) before its first element is accepted.
- Fairness: with both requesters continuously valid, grants alternate 0,1,0,1 starting at 0 after reset.
- Simultaneous events:
  - dp_valid_out for an earlier element coinciding with an element handshake: both counters update in the same cycle.
  - A requester raising req_valid in RESULT is not granted until IDLE.
- Widths: issued and recv are 5 bits. res_g is dp_g unmodified; the controller performs no arithmetic on it.

Test Plan:
- Requester 0 sends 21, 36, 64 (last on 64), no gaps, res_ready=1 → dp_clear pulse before the first element; res_g=76, res_id=0, res_len=3, res_err=0; res_valid rises DP_LAT+1 cycles after the 64 is accepted.
- Single element 255 with last from requester 1 → res_g=255, res_id=1, res_len=1.
- Both requesters valid from reset, each sending a 2-element vector (0: 3,4; 1: 5,12) → results in order id0 g=5, then id1 g=13. req_ready[1] stays 0 throughout requester 0's vector.
- Requester 0 sends 16 × 255 with req_last never asserted → res_len=16, res_g=1020, res_err=1; req_ready drops after the 16th element.
- Requester 0 sends 10, gap of 3 cycles, 20 (last), with res_ready held low for 5 cycles → res_g=22 stays stable with res_valid=1 until res_ready; then IDLE, and a new vector gets a fresh dp_clear.
- reset_n pulsed low during the second element of a 3-element vector → all outputs 0 immediately. After release, a new vector 6, 8 (last) returns res_g=10, res_id=0.
